// File: rtl/gfx_layer_compositor_if.sv
// Pixel-bundle and output-stream bundle for the layer compositor.
// The master drives layer samples and effect controls and consumes
// blended pixels. The slave is the compositor itself.
interface gfx_layer_compositor_if #(
  parameter int NUM_LAYERS = 5,
  parameter int CH_W       = 5,
  parameter int PRIO_W     = 2,
  parameter int LINE_WIDTH = 240
);
  localparam int COLOR_W = 3 * CH_W;
  localparam int X_W     = $clog2(LINE_WIDTH);

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic [NUM_LAYERS*PRIO_W-1:0]  layer_prio;
  logic [NUM_LAYERS-1:0]         layer_opaque;
  logic [NUM_LAYERS-1:0]         layer_enable;
  logic                         effects_enable;
  logic [COLOR_W-1:0]           backdrop;
  logic [NUM_LAYERS:0]          first_target;
  logic [NUM_LAYERS:0]          second_target;
  logic [1:0]                   blend_mode;
  logic [4:0]                   eva;
  logic [4:0]                   evb;
  logic [4:0]                   evy;
  logic                         frame_restart;
  logic                         out_valid;
  logic                         out_ready;
  logic [COLOR_W-1:0]           out_color;
  logic [X_W-1:0]               out_x;
  logic                         out_eol;

  modport master (
    output in_valid, layer_color, layer_prio, layer_opaque, layer_enable,
           effects_enable, backdrop, first_target, second_target,
           blend_mode, eva, evb, evy, frame_restart, out_ready,
    input  in_ready, out_valid, out_color, out_x, out_eol
  );

  modport slave (
    input  in_valid, layer_color, layer_prio, layer_opaque, layer_enable,
           effects_enable, backdrop, first_target, second_target,
           blend_mode, eva, evb, evy, frame_restart, out_ready,
    output in_ready, out_valid, out_color, out_x, out_eol
  );
endinterface

// File: rtl/gfx_layer_compositor.sv
// Per-pixel layer compositor: picks the two highest-priority visible
// layers (backdrop as fallback), applies alpha/brighten/darken, and
// streams the result through a 2-stage valid/ready pipeline while
// tracking the x position within the scanline.
module gfx_layer_compositor #(
  parameter int NUM_LAYERS = 5,
  parameter int CH_W       = 5,
  parameter int PRIO_W     = 2,
  parameter int LINE_WIDTH = 240
) (
  input logic                   clock,
  input logic                   rst_b,
  gfx_layer_compositor_if.slave bus
);
  localparam int COLOR_W = 3 * CH_W;
  localparam int X_W     = $clog2(LINE_WIDTH);
  localparam int IDX_W   = $clog2(NUM_LAYERS + 1);
  localparam int CH_MAX  = (1 << CH_W) - 1;

  function automatic logic [4:0] clamp_coef(input logic [4:0] k);
    return (k > 5'd16) ? 5'd16 : k;
  endfunction

  function automatic logic [CH_W-1:0] sat_ch(input logic [CH_W+5:0] v);
    if (v > (CH_W+6)'(CH_MAX)) return CH_W'(CH_MAX);
    return v[CH_W-1:0];
  endfunction

  function automatic logic [CH_W-1:0] alpha_ch(input logic [CH_W-1:0] c0,
                                               input logic [CH_W-1:0] c1,
                                               input logic [4:0]      ka,
                                               input logic [4:0]      kb);
    logic [CH_W+4:0] p0;
    logic [CH_W+4:0] p1;
    logic [CH_W+5:0] sum;
    p0  = (CH_W+5)'(c0) * (CH_W+5)'(ka);
    p1  = (CH_W+5)'(c1) * (CH_W+5)'(kb);
    sum = (CH_W+6)'(p0) + (CH_W+6)'(p1);
    return sat_ch(sum >> 4);
  endfunction

  function automatic logic [CH_W-1:0] brighten_ch(input logic [CH_W-1:0] c0,
                                                  input logic [4:0]      ky);
    logic [CH_W-1:0] head;
    logic [CH_W+4:0] p;
    head = CH_W'(CH_MAX) - c0;
    p    = (CH_W+5)'(head) * (CH_W+5)'(ky);
    // p >> 4 never exceeds head because ky <= 16, so the sum cannot wrap
    return c0 + CH_W'(p >> 4);
  endfunction

  function automatic logic [CH_W-1:0] darken_ch(input logic [CH_W-1:0] c0,
                                                input logic [4:0]      ky);
    logic [CH_W+4:0] p;
    p = (CH_W+5)'(c0) * (CH_W+5)'(ky);
    return c0 - CH_W'(p >> 4);
  endfunction

  logic                vld_p1;
  logic                vld_p2;
  logic [X_W-1:0]      x_cnt;
  logic [COLOR_W-1:0]  color_p2;
  logic                en;
  logic                accept;

  // The output register is the only place a stall can originate
  assign en          = !(vld_p2 && !bus.out_ready);
  assign bus.in_ready = rst_b && en && !bus.frame_restart;
  assign accept      = bus.in_valid && bus.in_ready;

  // ---- stage 0 -> 1 : priority selection ----
  logic [NUM_LAYERS-1:0] cand;
  logic                  found0;
  logic                  found1;
  logic [PRIO_W-1:0]     best0;
  logic [PRIO_W-1:0]     best1;
  logic [IDX_W-1:0]      sel0;
  logic [IDX_W-1:0]      sel1;
  logic [COLOR_W-1:0]    col0;
  logic [COLOR_W-1:0]    col1;

  // Two linear scans; strict '<' keeps the lowest index on priority ties
  always_comb begin
    cand   = bus.layer_opaque & bus.layer_enable;
    found0 = 1'b0;
    best0  = '0;
    sel0   = IDX_W'(NUM_LAYERS);
    col0   = bus.backdrop;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cand[i] && (!found0 || bus.layer_prio[i*PRIO_W +: PRIO_W] < best0)) begin
        found0 = 1'b1;
        best0  = bus.layer_prio[i*PRIO_W +: PRIO_W];
        sel0   = IDX_W'(i);
        col0   = bus.layer_color[i*COLOR_W +: COLOR_W];
      end
    end
    found1 = 1'b0;
    best1  = '0;
    sel1   = IDX_W'(NUM_LAYERS);
    col1   = bus.backdrop;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cand[i] && (IDX_W'(i) != sel0) &&
          (!found1 || bus.layer_prio[i*PRIO_W +: PRIO_W] < best1)) begin
        found1 = 1'b1;
        best1  = bus.layer_prio[i*PRIO_W +: PRIO_W];
        sel1   = IDX_W'(i);
        col1   = bus.layer_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  logic [COLOR_W-1:0] col0_p1;
  logic [COLOR_W-1:0] col1_p1;
  logic [IDX_W-1:0]   idx0_p1;
  logic [IDX_W-1:0]   idx1_p1;
  logic [NUM_LAYERS:0] ft_p1;
  logic [NUM_LAYERS:0] st_p1;
  logic               fx_p1;
  logic [1:0]         mode_p1;
  logic [4:0]         eva_p1;
  logic [4:0]         evb_p1;
  logic [4:0]         evy_p1;

  // Stage-1 valid: flushed by frame_restart, holds while stalled
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b)                 vld_p1 <= 1'b0;
    else if (bus.frame_restart) vld_p1 <= 1'b0;
    else if (en)                vld_p1 <= accept;
  end

  // Stage-1 data captured only on an accepted bundle
  always_ff @(posedge clock) begin
    if (accept) begin
      col0_p1 <= col0;
      col1_p1 <= col1;
      idx0_p1 <= sel0;
      idx1_p1 <= sel1;
      ft_p1   <= bus.first_target;
      st_p1   <= bus.second_target;
      fx_p1   <= bus.effects_enable;
      mode_p1 <= bus.blend_mode;
      eva_p1  <= bus.eva;
      evb_p1  <= bus.evb;
      evy_p1  <= bus.evy;
    end
  end

  // ---- stage 1 -> 2 : colour effect ----
  logic [4:0]         eva_c;
  logic [4:0]         evb_c;
  logic [4:0]         evy_c;
  logic               apply_alpha;
  logic               apply_light;
  logic [COLOR_W-1:0] blended;

  assign eva_c       = clamp_coef(eva_p1);
  assign evb_c       = clamp_coef(evb_p1);
  assign evy_c       = clamp_coef(evy_p1);
  assign apply_light = ft_p1[idx0_p1] && fx_p1;
  assign apply_alpha = apply_light && st_p1[idx1_p1];

  // Per-channel effect; anything not enabled passes the top colour through
  always_comb begin
    blended = col0_p1;
    for (int ch = 0; ch < 3; ch++) begin
      case (mode_p1)
        2'b01: if (apply_alpha)
          blended[ch*CH_W +: CH_W] = alpha_ch(col0_p1[ch*CH_W +: CH_W],
                                              col1_p1[ch*CH_W +: CH_W], eva_c, evb_c);
        2'b10: if (apply_light)
          blended[ch*CH_W +: CH_W] = brighten_ch(col0_p1[ch*CH_W +: CH_W], evy_c);
        2'b11: if (apply_light)
          blended[ch*CH_W +: CH_W] = darken_ch(col0_p1[ch*CH_W +: CH_W], evy_c);
        default: ;
      endcase
    end
  end

  // Output register; colour is cleared on reset so the idle bus reads zero
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      vld_p2   <= 1'b0;
      color_p2 <= '0;
    end else if (bus.frame_restart) begin
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) color_p2 <= blended;
    end
  end

  // ---- output : scanline position ----
  // Advances only on a completed output transfer and wraps at end of line
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b)                      x_cnt <= '0;
    else if (bus.frame_restart)      x_cnt <= '0;
    else if (vld_p2 && bus.out_ready)
      x_cnt <= (x_cnt == X_W'(LINE_WIDTH - 1)) ? '0 : x_cnt + X_W'(1);
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_color = color_p2;
  assign bus.out_x     = x_cnt;
  assign bus.out_eol   = vld_p2 && (x_cnt == X_W'(LINE_WIDTH - 1));
endmodule

// File: tb/tb_gfx_layer_compositor.sv
// Bench for gfx_layer_compositor: directed effect cases, a randomized
// full scanline with random back-pressure, frame_restart and async reset.
module tb_gfx_layer_compositor;
  localparam int NL = 5;
  localparam int LW = 240;

  logic clock = 1'b0;
  logic rst_b = 1'b0;
  always #5 clock = ~clock;

  gfx_layer_compositor_if #(.NUM_LAYERS(NL), .CH_W(5), .PRIO_W(2), .LINE_WIDTH(LW)) bus ();

  gfx_layer_compositor #(.NUM_LAYERS(NL), .CH_W(5), .PRIO_W(2), .LINE_WIDTH(LW)) dut (
    .clock (clock),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [14:0] q[$];
  int exp_x      = 0;
  int out_count  = 0;
  int eol_count  = 0;
  int sent       = 0;
  logic last_accept;
  logic [14:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: insertion pick of best two candidates, then integer effect math
  function automatic logic [14:0] ref_pixel();
    int pr[NL];
    logic [14:0] col[NL];
    int top = -1, sec = -1, ti, si, a, b, y, x0, x1, r;
    logic [14:0] c0, c1, res;
    for (int i = 0; i < NL; i++) begin
      pr[i]  = int'(bus.layer_prio[i*2 +: 2]);
      col[i] = bus.layer_color[i*15 +: 15];
    end
    for (int i = 0; i < NL; i++) begin
      if (bus.layer_opaque[i] && bus.layer_enable[i]) begin
        if (top < 0 || pr[i] < pr[top]) begin sec = top; top = i; end
        else if (sec < 0 || pr[i] < pr[sec]) sec = i;
      end
    end
    ti = (top < 0) ? NL : top;
    si = (sec < 0) ? NL : sec;
    c0 = (top < 0) ? bus.backdrop : col[top];
    c1 = (sec < 0) ? bus.backdrop : col[sec];
    a = (bus.eva > 16) ? 16 : int'(bus.eva);
    b = (bus.evb > 16) ? 16 : int'(bus.evb);
    y = (bus.evy > 16) ? 16 : int'(bus.evy);
    res = c0;
    for (int ch = 0; ch < 3; ch++) begin
      x0 = int'(c0[ch*5 +: 5]);
      x1 = int'(c1[ch*5 +: 5]);
      r  = x0;
      case (bus.blend_mode)
        2'b01: if (bus.first_target[ti] && bus.second_target[si] && bus.effects_enable) begin
          r = (x0 * a + x1 * b) / 16;
          if (r > 31) r = 31;
        end
        2'b10: if (bus.first_target[ti] && bus.effects_enable) r = x0 + ((31 - x0) * y) / 16;
        2'b11: if (bus.first_target[ti] && bus.effects_enable) r = x0 - (x0 * y) / 16;
        default: ;
      endcase
      res[ch*5 +: 5] = 5'(r);
    end
    return res;
  endfunction

  // One clock: score what transfers at the coming edge, then advance
  task automatic tick();
    logic stalled;
    logic [14:0] hold_c;
    logic [7:0]  hold_x;
    logic [14:0] e;
    last_accept = 1'b0;
    #1;
    stalled = 1'b0;
    if (rst_b && bus.frame_restart) begin
      q.delete();
      exp_x = 0;
    end else if (rst_b) begin
      check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_color", 32'(bus.out_color), 32'(e));
          check("out_x", 32'(bus.out_x), 32'(exp_x));
          check("out_eol", 32'(bus.out_eol), 32'(exp_x == LW - 1));
          last_out = bus.out_color;
          out_count++;
          if (bus.out_eol) eol_count++;
          exp_x = (exp_x + 1) % LW;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      hold_c  = bus.out_color;
      hold_x  = bus.out_x;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_pixel());
        last_accept = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    if (stalled) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_color", 32'(bus.out_color), 32'(hold_c));
      check("stall_x", 32'(bus.out_x), 32'(hold_x));
    end
  endtask

  task automatic clear_layers();
    bus.layer_color    = '0;
    bus.layer_prio     = '1;
    bus.layer_opaque   = '0;
    bus.layer_enable   = '1;
    bus.effects_enable = 1'b1;
    bus.backdrop       = '0;
    bus.first_target   = '0;
    bus.second_target  = '0;
    bus.blend_mode     = 2'b00;
    bus.eva            = '0;
    bus.evb            = '0;
    bus.evy            = '0;
  endtask

  task automatic set_layer(input int i, input logic [14:0] c, input logic [1:0] p);
    bus.layer_color[i*15 +: 15] = c;
    bus.layer_prio[i*2 +: 2]    = p;
    bus.layer_opaque[i]         = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NL; i++) begin
      bus.layer_color[i*15 +: 15] = 15'($urandom);
      bus.layer_prio[i*2 +: 2]    = 2'($urandom);
    end
    bus.layer_opaque   = 5'($urandom);
    bus.layer_enable   = 5'($urandom | $urandom);
    bus.effects_enable = ($urandom_range(0, 3) != 0);
    bus.backdrop       = 15'($urandom);
    bus.first_target   = 6'($urandom);
    bus.second_target  = 6'($urandom);
    bus.blend_mode     = 2'($urandom);
    bus.eva            = 5'($urandom);
    bus.evb            = 5'($urandom);
    bus.evy            = 5'($urandom);
  endtask

  task automatic send_one();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.frame_restart = 1'b0;
    bus.out_ready     = 1'b1;
    clear_layers();

    // reset state
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_color", 32'(bus.out_color), 32'd0);
    check("rst_x", 32'(bus.out_x), 32'd0);
    check("rst_eol", 32'(bus.out_eol), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_b = 1'b1;
    @(posedge clock);
    #1;

    // single opaque layer, 2-cycle latency
    set_layer(2, 15'h7FFF, 2'd1);
    bus.in_valid = 1'b1;
    #1;
    check("t1_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("t1_lat1", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_lat2", 32'(bus.out_valid), 32'd1);
    check("t1_color", 32'(bus.out_color), 32'h7FFF);
    check("t1_x", 32'(bus.out_x), 32'd0);
    repeat (2) tick();

    // priority tie -> lowest index, then 50/50 alpha
    clear_layers();
    set_layer(0, 15'h515F, 2'd2);
    set_layer(3, 15'h7CC0, 2'd2);
    send_one();
    check("tie_low_index", 32'(last_out), 32'h515F);
    bus.blend_mode    = 2'b01;
    bus.eva           = 5'd8;
    bus.evb           = 5'd8;
    bus.first_target  = '1;
    bus.second_target = '1;
    send_one();
    check("alpha_half", 32'(last_out), 32'h650F);

    // alpha saturation
    clear_layers();
    set_layer(1, 15'h7FFF, 2'd0);
    set_layer(4, 15'h7FFF, 2'd3);
    bus.blend_mode = 2'b01; bus.eva = 5'd16; bus.evb = 5'd16;
    bus.first_target = '1; bus.second_target = '1;
    send_one();
    check("alpha_sat", 32'(last_out), 32'h7FFF);

    // brighten with clamped coefficient, darken, effects disabled
    clear_layers();
    set_layer(0, 15'h0000, 2'd0);
    bus.first_target = '1; bus.blend_mode = 2'b10; bus.evy = 5'd20;
    send_one();
    check("brighten_clamp", 32'(last_out), 32'h7FFF);
    bus.layer_color[14:0] = 15'h7FFF;
    bus.blend_mode = 2'b11; bus.evy = 5'd16;
    send_one();
    check("darken_full", 32'(last_out), 32'h0000);
    bus.effects_enable = 1'b0;
    send_one();
    check("fx_disabled", 32'(last_out), 32'h7FFF);

    // backdrop only, and alpha with backdrop not a first target
    clear_layers();
    bus.backdrop = 15'h1234;
    send_one();
    check("backdrop", 32'(last_out), 32'h1234);
    bus.blend_mode = 2'b01; bus.eva = 5'd16; bus.evb = 5'd16;
    bus.first_target = 6'h1F; bus.second_target = '1;
    send_one();
    check("backdrop_no_fx", 32'(last_out), 32'h1234);

    // full scanline with random back-pressure
    bus.frame_restart = 1'b1;
    tick();
    bus.frame_restart = 1'b0;
    out_count = 0;
    eol_count = 0;
    sent      = 0;
    for (int cyc = 0; cyc < 4000 && (sent < LW || q.size() != 0); cyc++) begin
      if (sent < LW && $urandom_range(0, 3) != 0) begin
        rand_inputs();
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom);
      tick();
      if (last_accept) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stream_sent", 32'(sent), 32'(LW));
    check("stream_out", 32'(out_count), 32'(LW));
    check("stream_eol", 32'(eol_count), 32'd1);
    check("stream_x_wrap", 32'(bus.out_x), 32'd0);
    rand_inputs();
    send_one();
    check("post_line_x", 32'(exp_x), 32'd1);

    // frame_restart with two pixels in flight
    bus.out_ready = 1'b0;
    rand_inputs();
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.frame_restart = 1'b1;
    #1;
    check("restart_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.frame_restart = 1'b0;
    bus.in_valid = 1'b0;
    check("restart_valid", 32'(bus.out_valid), 32'd0);
    check("restart_x", 32'(bus.out_x), 32'd0);
    tick();
    check("restart_no_stale", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    rand_inputs();
    send_one();
    check("restart_next_x", 32'(out_count > 0 && exp_x == 1), 32'd1);

    // asynchronous reset mid-line
    repeat (6) begin
      rand_inputs();
      bus.in_valid = 1'b1;
      tick();
    end
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_color", 32'(bus.out_color), 32'd0);
    check("arst_x", 32'(bus.out_x), 32'd0);
    check("arst_eol", 32'(bus.out_eol), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    q.delete();
    exp_x = 0;
    bus.in_valid = 1'b0;
    #2;
    rst_b = 1'b1;
    @(posedge clock);
    #1;
    check("arst_no_stale", 32'(bus.out_valid), 32'd0);
    rand_inputs();
    send_one();
    check("arst_next_x", 32'(exp_x), 32'd1);
    check("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
